// File: rtl/demux_rr_sequencer.sv
// Serial-to-demux feeder: bursts of BURST_LEN bits rotate round-robin
// across enabled channels, with a registered, backpressured output stage.
module demux_rr_sequencer #(
  parameter int BURST_LEN = 8,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] ch_en,
  input  logic       in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       dout,
  output logic [1:0] S,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       burst_done,
  output logic [1:0] cur_ch
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST_LEN - 1);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             last;
  logic [1:0]       first_ch;
  logic [1:0]       next_ch;

  function automatic logic [1:0] lowest(input logic [3:0] en);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (en[i]) r = 2'(i);
    return r;
  endfunction

  // Search upward from cur_ch+1, wrapping; offset 4 lands back on cur_ch.
  function automatic logic [1:0] rotate(input logic [1:0] ch,
                                        input logic [3:0] en);
    logic [1:0] r;
    logic [1:0] idx;
    r = ch;
    for (int k = 4; k >= 1; k--) begin
      idx = ch + 2'(k);
      if (en[idx]) r = idx;
    end
    return r;
  endfunction

  assign first_ch = lowest(ch_en);
  assign next_ch  = rotate(cur_ch, ch_en);
  assign in_ready = (state == RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign last     = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cur_ch     <= 2'd0;
      cnt        <= '0;
      S          <= 2'd0;
      dout       <= 1'b0;
      out_valid  <= 1'b0;
      burst_done <= 1'b0;
    end else begin
      burst_done <= accept && last;
      if (accept) begin
        dout      <= in_data;
        S         <= cur_ch;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (ch_en != 4'd0) begin
            state  <= RUN;
            cur_ch <= first_ch;
            cnt    <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            if (last) begin
              cnt <= '0;
              if (ch_en == 4'd0) state <= IDLE;
              else cur_ch <= next_ch;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_demux_rr_sequencer.sv
// Self-checking bench for demux_rr_sequencer: table vectors, directed
// corner sequences and a randomized run against a behavioural model.
module tb_demux_rr_sequencer;

  localparam int BL = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ch_en;
  logic       in_data;
  logic       in_valid;
  logic       in_ready;
  logic       dout;
  logic [1:0] S;
  logic       out_valid;
  logic       out_ready;
  logic       burst_done;
  logic [1:0] cur_ch;

  demux_rr_sequencer #(.BURST_LEN(BL), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .ch_en(ch_en), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .dout(dout), .S(S),
    .out_valid(out_valid), .out_ready(out_ready),
    .burst_done(burst_done), .cur_ch(cur_ch)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: mode, channel, position in burst, one-deep output.
  bit m_run;
  int m_ch;
  int m_pos;
  bit m_have;
  bit m_dout;
  int m_s;
  bit m_done;
  bit m_acc;

  task automatic chk(input string name, input logic [3:0] act,
                     input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest_en(input logic [3:0] en);
    for (int i = 0; i < 4; i++)
      if (en[i]) return i;
    return 0;
  endfunction

  function automatic int next_en(input int ch, input logic [3:0] en);
    for (int k = 1; k <= 4; k++)
      if (en[(ch + k) % 4]) return (ch + k) % 4;
    return ch;
  endfunction

  function automatic bit exp_ready();
    return m_run && (!m_have || out_ready);
  endfunction

  task automatic model_edge();
    m_acc = 1'b0;
    if (rst) begin
      m_run = 0; m_ch = 0; m_pos = 0;
      m_have = 0; m_dout = 0; m_s = 0; m_done = 0;
      return;
    end
    m_acc  = exp_ready() && in_valid;
    m_done = 0;
    if (m_acc) begin
      m_dout = in_data;
      m_s    = m_ch;
      m_have = 1;
    end else if (out_ready) begin
      m_have = 0;
    end
    if (!m_run) begin
      if (ch_en != 0) begin
        m_run = 1;
        m_ch  = lowest_en(ch_en);
        m_pos = 0;
      end
    end else if (m_acc) begin
      m_pos++;
      if (m_pos == BL) begin
        m_pos  = 0;
        m_done = 1;
        if (ch_en == 0) m_run = 0;
        else m_ch = next_en(m_ch, ch_en);
      end
    end
  endtask

  task automatic step(input logic r, input logic [3:0] en, input logic v,
                      input logic rdy, input logic d);
    rst = r; ch_en = en; in_valid = v; out_ready = rdy; in_data = d;
    #1;
    if (!r) chk("in_ready", in_ready, exp_ready());
    @(posedge clk);
    model_edge();
    #1;
    chk("dout", dout, m_dout);
    chk("S", S, 4'(m_s));
    chk("out_valid", out_valid, m_have);
    chk("burst_done", burst_done, m_done);
    chk("cur_ch", cur_ch, 4'(m_ch));
  endtask

  typedef struct {
    logic       d;
    logic [1:0] s;
    logic       done;
  } vec_t;

  vec_t tbl[32];
  logic d0;
  int   acc;

  initial begin
    for (int i = 0; i < 32; i++) begin
      tbl[i].d    = 1'($urandom);
      tbl[i].s    = 2'(i / BL);
      tbl[i].done = ((i % BL) == BL - 1);
    end

    // Reset state
    step(1, 4'h0, 0, 1, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_S", S, 0);
    chk("rst_done", burst_done, 0);
    chk("rst_cur_ch", cur_ch, 0);
    step(0, 4'h0, 1, 1, 0);
    chk("idle_in_ready", in_ready, 0);

    // Four channels, full rotation from the table
    step(0, 4'hf, 1, 1, 0);
    for (int i = 0; i < 32; i++) begin
      step(0, 4'hf, 1, 1, tbl[i].d);
      chk("tbl_dout", dout, tbl[i].d);
      chk("tbl_S", S, tbl[i].s);
      chk("tbl_valid", out_valid, 1);
      chk("tbl_done", burst_done, tbl[i].done);
    end

    // Alternate channels 1 and 3
    step(1, 4'h0, 0, 1, 0);
    step(0, 4'ha, 1, 1, 0);
    for (int i = 0; i < 32; i++) begin
      step(0, 4'ha, 1, 1, 1'($urandom));
      chk("alt_S", S, ((i / BL) % 2 == 0) ? 4'd1 : 4'd3);
    end

    // Backpressure mid-burst
    step(1, 4'h0, 0, 1, 0);
    step(0, 4'hf, 1, 1, 0);
    d0 = 0;
    for (int i = 0; i < 3; i++) begin
      d0 = 1'($urandom);
      step(0, 4'hf, 1, 1, d0);
    end
    for (int i = 0; i < 5; i++) begin
      step(0, 4'hf, 1, 0, ~d0);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_dout", dout, d0);
      chk("stall_S", S, 0);
      chk("stall_valid", out_valid, 1);
    end
    acc = 3;
    for (int i = 0; i < 5; i++) begin
      step(0, 4'hf, 1, 1, 1'($urandom));
      if (m_acc) acc++;
      chk("stall_resume_done", burst_done, acc == BL);
    end
    chk("stall_resume_ch", cur_ch, 1);

    // Enable mask cleared mid-burst on channel 2
    step(1, 4'h0, 0, 1, 0);
    step(0, 4'h4, 1, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 4'h4, 1, 1, 1'($urandom));
    for (int i = 3; i < BL; i++) begin
      step(0, 4'h0, 1, 1, 1'($urandom));
      chk("clr_S", S, 2);
      chk("clr_done", burst_done, i == BL - 1);
    end
    #1;
    chk("clr_idle_ready", in_ready, 0);
    step(0, 4'h0, 1, 1, 0);
    chk("clr_drained", out_valid, 0);

    // Single channel repeats
    step(1, 4'h0, 0, 1, 0);
    step(0, 4'h4, 1, 1, 0);
    for (int i = 0; i < 2 * BL; i++) begin
      step(0, 4'h4, 1, 1, 1'($urandom));
      chk("one_S", S, 2);
      chk("one_done", burst_done, (i % BL) == BL - 1);
    end

    // Reset mid-burst then a fresh burst on channel 0
    step(1, 4'h0, 0, 1, 0);
    step(0, 4'h2, 1, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 4'h2, 1, 1, 1'($urandom));
    step(1, 4'h2, 1, 0, 1);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_S", S, 0);
    step(0, 4'h1, 1, 1, 0);
    for (int i = 0; i < BL; i++) begin
      step(0, 4'h1, 1, 1, 1'($urandom));
      chk("fresh_S", S, 0);
      chk("fresh_done", burst_done, i == BL - 1);
    end

    // Randomized run against the model
    begin
      logic [3:0] en;
      en = 4'hf;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 24) == 0) en = 4'($urandom);
        step(1'($urandom_range(0, 199) == 0), en,
             1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 2) != 0), 1'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_rr_sequencer.md
Name: demux_rr_sequencer

Overview:
- Upstream feeder for the 1-to-4 demultiplexer stage: accepts a serial bit stream over a valid/ready handshake and produces the registered data bit plus the 2-bit channel select that steers it.
- Bits go to enabled channels in bursts of BURST_LEN, rotating round-robin across the channels set in a 4-bit enable mask.
- Registered output stage with backpressure, so it can drive either the combinational demux directly or a buffered consumer.

Parameters:
- BURST_LEN, 8: bits delivered to one channel before rotating; legal range 1..256.
- CNT_W, 8: width of the burst counter; must satisfy 2^CNT_W >= BURST_LEN.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- ch_en  input  4  channel enable mask; bit n enables channel n.
- in_data  input  1  serial data bit.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block accepts in_data this cycle.
- dout  output  1  data bit to demux input.
- S  output  2  channel select to demux.
- out_valid  output  1  dout/S valid.
- out_ready  input  1  downstream accepts dout/S this cycle; tie high for the combinational demux.
- burst_done  output  1  one-cycle pulse when the last bit of a burst is accepted on input.
- cur_ch  output  2  channel owning the current burst.

Behaviour:
- Reset, synchronous, active-high, values on the first edge with rst=1:
  - state=IDLE, cur_ch=0, burst counter=0.
  - S=0, dout=0, out_valid=0, burst_done=0.
  - in_ready=0 while in IDLE.
  - Reset mid-burst discards the partial burst and any held output bit.
- States:
  - IDLE: in_ready=0. When ch_en!=0, move to RUN next cycle with cur_ch=lowest set bit of ch_en and counter=0.
  - RUN: in_ready = (!out_valid || out_ready).
- Accept: in_valid && in_ready. On accept:
  - dout<=in_data, S<=cur_ch, out_valid<=1. Latency from accept to out_valid is 1 cycle.
  - Counter increments. If counter==BURST_LEN-1, the burst completes.
- Output hold: if out_valid && !out_ready, dout/S/out_valid are held stable and in_ready=0.
- Output drain: out_valid clears on out_ready when there is no new accept in the same cycle. Simultaneous out_ready and accept loads the new bit back-to-back with no bubble.
- Burst completion, same edge as the final accept:
  - burst_done pulses 1 cycle and the counter returns to 0.
  - cur_ch advances to the next enabled channel strictly above cur_ch, wrapping 3->0, using ch_en sampled at that edge.
  - If cur_ch is the only enabled bit, it stays.
  - If ch_en==0, go to IDLE. The already-loaded output bit still drains normally.
- ch_en changes mid-burst do not affect the current burst; it completes on cur_ch even if that channel was disabled.
- BURST_LEN=1: every accept is a burst end, giving per-bit rotation.
- in_valid low mid-burst: counter holds, no timeout.
- S is never updated without an accompanying dout load; the demux never sees S change while out_valid=1 and out_ready=0.

Test Plan:
- Reset then ch_en=4'b1111, BURST_LEN=8, in_valid=1, out_ready=1, 32 bits -> S=0 for bits 0-7, 1 for 8-15, 2 for 16-23, 3 for 24-31; burst_done pulses at accepts 8, 16, 24, 32; one output per cycle after 1-cycle latency.
- ch_en=4'b1010 -> sequence S=1,3,1,3 per burst; channels 0 and 2 never selected.
- out_ready=0 for 5 cycles mid-burst with in_valid=1 -> dout/S held; in_ready=0 for those cycles; no bit lost or duplicated; counter resumes correctly.
- Clear ch_en to 0 at bit 3 of a burst on channel 2 -> the remaining 5 bits still go to S=2; burst_done pulses; block enters IDLE with in_ready=0.
- ch_en=4'b0100 only -> S stays 2 across consecutive bursts; burst_done every 8 accepts.
- Assert rst at bit 5 of a burst -> next cycle out_valid=0, S=0, counter=0; after release with ch_en=4'b0001, a fresh full 8-bit burst is delivered on channel 0.
